// File: rtl/junction_scheduler.sv
// Highway / country-road junction light scheduler: six-phase Moore FSM with a phase down-counter.
// Optional CR_EARLY_END_EN ends country-road green early once the road clears.
module junction_scheduler #(
  parameter int unsigned HW_MIN_GREEN = 16,
  parameter int unsigned CR_MAX_GREEN = 12,
  parameter int unsigned CR_MIN_GREEN = 4,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALLRED_TIME  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_sensor,
  output logic       enable_highway,
  output logic       enable_countryroad,
  output logic       timeout,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HW_GREEN  = 3'd0,
    HW_YELLOW = 3'd1,
    RED1      = 3'd2,
    CR_GREEN  = 3'd3,
    CR_YELLOW = 3'd4,
    RED2      = 3'd5
  } state_t;

  localparam logic [7:0] HW_LOAD     = 8'(HW_MIN_GREEN - 1);
  localparam logic [7:0] CR_LOAD     = 8'(CR_MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_TIME - 1);
`ifdef CR_EARLY_END_EN
  // Counter value reached once CR_MIN_GREEN cycles of green have elapsed.
  localparam logic [7:0] CR_EARLY_LIMIT = 8'(CR_MAX_GREEN - CR_MIN_GREEN);
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       en_hw_q, en_hw_d;
  logic       en_cr_q, en_cr_d;
  logic       timeout_q, timeout_d;
  logic       cnt_zero;
  logic       entering;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HW_GREEN:  if (cnt_zero && req_q) state_d = HW_YELLOW;
      HW_YELLOW: if (cnt_zero) state_d = RED1;
      RED1:      if (cnt_zero) state_d = CR_GREEN;
`ifdef CR_EARLY_END_EN
      CR_GREEN:  if (cnt_zero || ((cnt_q <= CR_EARLY_LIMIT) && !car_sensor)) state_d = CR_YELLOW;
`else
      CR_GREEN:  if (cnt_zero) state_d = CR_YELLOW;
`endif
      CR_YELLOW: if (cnt_zero) state_d = RED2;
      RED2:      if (cnt_zero) state_d = HW_GREEN;
      default:   state_d = HW_GREEN;
    endcase
  end

  always_comb begin
    entering = (state_d != state_q);
    cnt_d    = cnt_zero ? '0 : (cnt_q - 8'd1);
    if (entering) begin
      case (state_d)
        HW_GREEN:            cnt_d = HW_LOAD;
        HW_YELLOW, CR_YELLOW: cnt_d = YELLOW_LOAD;
        RED1, RED2:          cnt_d = ALLRED_LOAD;
        CR_GREEN:            cnt_d = CR_LOAD;
        default:             cnt_d = HW_LOAD;
      endcase
    end

    // A car seen in the same cycle as the clear keeps the request pending.
    req_d = req_q;
    if (entering && (state_d == CR_GREEN)) req_d = 1'b0;
    if (car_sensor) req_d = 1'b1;

    en_hw_d   = (state_d == HW_GREEN) || (state_d == HW_YELLOW);
    en_cr_d   = (state_d == CR_GREEN) || (state_d == CR_YELLOW);
    timeout_d = entering;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HW_GREEN;
      cnt_q     <= HW_LOAD;
      req_q     <= 1'b0;
      en_hw_q   <= 1'b1;
      en_cr_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      en_hw_q   <= en_hw_d;
      en_cr_q   <= en_cr_d;
      timeout_q <= timeout_d;
    end
  end

  assign enable_highway     = en_hw_q;
  assign enable_countryroad = en_cr_q;
  assign timeout            = timeout_q;
  assign phase              = state_q;

endmodule

// File: tb/tb_junction_scheduler.sv
// Directed bench for junction_scheduler: expected phase changes queued per scenario, matched against timeout pulses.
module tb_junction_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_sensor;
  logic       enable_highway;
  logic       enable_countryroad;
  logic       timeout;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int t0     = 0;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
  } exp_t;
  exp_t sb[$];

`ifdef CR_EARLY_END_EN
  localparam int CRY = 25;
`else
  localparam int CRY = 33;
`endif

  junction_scheduler #(
    .HW_MIN_GREEN(16),
    .CR_MAX_GREEN(12),
    .CR_MIN_GREEN(4),
    .YELLOW_TIME (3),
    .ALLRED_TIME (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .car_sensor        (car_sensor),
    .enable_highway    (enable_highway),
    .enable_countryroad(enable_countryroad),
    .timeout           (timeout),
    .phase             (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [2:0] p);
    exp_t e;
    e.cyc = c;
    e.ph  = p;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while ((edges - t0) < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic car_after);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    car_sensor = car_after;
    t0         = edges;
  endtask

  task automatic push_full_cycle();
    push_exp(16, 3'd1);
    push_exp(19, 3'd2);
    push_exp(21, 3'd3);
    push_exp(33, 3'd4);
    push_exp(36, 3'd5);
    push_exp(38, 3'd0);
  endtask

  // Monitor: every phase change must match the head of the queue; otherwise phase must hold.
  logic [2:0] prev_ph = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    int   cyc;
    #1;
    if (rst) begin
      prev_ph = 3'd0;
    end else begin
      cyc = edges - t0;
      check("exclusive", 32'(enable_highway & enable_countryroad), 32'd0);
      check("en_hw_decode", 32'(enable_highway), 32'(phase <= 3'd1));
      check("en_cr_decode", 32'(enable_countryroad), 32'((phase == 3'd3) || (phase == 3'd4)));
      if (timeout) begin
        if (sb.size() == 0) begin
          check("spurious_timeout", 32'(timeout), 32'd0);
        end else begin
          e = sb.pop_front();
          check("timeout_cycle", 32'(cyc), 32'(e.cyc));
          check("timeout_phase", 32'(phase), 32'(e.ph));
        end
      end else begin
        check("phase_hold", 32'(phase), 32'(prev_ph));
      end
      prev_ph = phase;
    end
  end

  initial begin
    rst        = 1'b1;
    car_sensor = 1'b0;
    #1;
    check("rst_en_hw", 32'(enable_highway), 32'd1);
    check("rst_en_cr", 32'(enable_countryroad), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0  = edges;

    // Idle highway: no requests for 100 cycles.
    wait_until(100);
    check("idle_phase", 32'(phase), 32'd0);
    check("idle_en_hw", 32'(enable_highway), 32'd1);
    check("idle_sb_empty", 32'(sb.size()), 32'd0);

    // Sensor held from cycle 0: one full rotation.
    do_reset(1'b1);
    push_full_cycle();
    wait_until(25);
    check("held_cr_phase", 32'(phase), 32'd3);
    check("held_cr_en", 32'(enable_countryroad), 32'd1);
    wait_until(40);
    check("held_sb_empty", 32'(sb.size()), 32'd0);

    // Single-cycle pulse at cycle 5 is latched; no second rotation afterwards.
    do_reset(1'b0);
    push_full_cycle();
    wait_until(5);
    car_sensor = 1'b1;
    @(negedge clk);
    car_sensor = 1'b0;
    wait_until(80);
    check("pulse_sb_empty", 32'(sb.size()), 32'd0);
    check("pulse_end_phase", 32'(phase), 32'd0);

    // Sensor drops on entering country-road green.
    do_reset(1'b1);
    push_exp(16, 3'd1);
    push_exp(19, 3'd2);
    push_exp(21, 3'd3);
    push_exp(CRY, 3'd4);
    push_exp(CRY + 3, 3'd5);
    push_exp(CRY + 5, 3'd0);
    wait_until(21);
    car_sensor = 1'b0;
    wait_until(CRY + 6);
    check("drop_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of country-road green.
    do_reset(1'b1);
    push_exp(16, 3'd1);
    push_exp(19, 3'd2);
    push_exp(21, 3'd3);
    wait_until(25);
    check("pre_rst_phase", 32'(phase), 32'd3);
    check("pre_rst_sb_empty", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_en_cr", 32'(enable_countryroad), 32'd0);
    check("midrst_en_hw", 32'(enable_highway), 32'd1);
    check("midrst_phase", 32'(phase), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    car_sensor = 1'b1;
    t0         = edges;
    push_exp(16, 3'd1);
    wait_until(15);
    check("post_rst_min_green", 32'(phase), 32'd0);
    wait_until(17);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/junction_scheduler.md
JUNCTION_SCHEDULER -- requirements
Module: junction_scheduler

Interface
REQ-001 SHALL have parameter HW_MIN_GREEN, default 16, meaning the minimum highway green phase length in cycles (1..255).
REQ-002 SHALL have parameter CR_MAX_GREEN, default 12, meaning the maximum country-road green phase length in cycles (1..255).
REQ-003 SHALL have parameter CR_MIN_GREEN, default 4, meaning the minimum country-road green phase length in cycles (1..CR_MAX_GREEN).
REQ-004 SHALL have parameter YELLOW_TIME, default 3, meaning the length of each yellow phase in cycles (1..255).
REQ-005 SHALL have parameter ALLRED_TIME, default 2, meaning the length of each all-red phase in cycles (1..255).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-008 SHALL have port car_sensor, input, 1 bit, asserted when a vehicle waits on the country road; sampled every cycle.
REQ-009 SHALL have port enable_highway, output, 1 bit, the highway light enable.
REQ-010 SHALL have port enable_countryroad, output, 1 bit, which drives the countryroad light block.
REQ-011 SHALL have port timeout, output, 1 bit, a single-cycle phase-change strobe shared by both light blocks.
REQ-012 SHALL have port phase, output, 3 bits, the current state encoding.

Function
REQ-013 SHALL implement a six-state FSM with these transitions:
- HW_GREEN=0 -> HW_YELLOW=1 -> RED1=2 -> CR_GREEN=3 -> CR_YELLOW=4 -> RED2=5 -> HW_GREEN.
REQ-014 SHALL load an 8-bit down-counter with (phase length - 1) on entry to each phase and decrement it each cycle, saturating at 0.
- As a result, each timed phase lasts exactly its parameter in cycles.
REQ-015 SHALL hold HW_GREEN while the counter is nonzero or the request flag is 0.
- SHALL leave HW_GREEN on the cycle after counter==0 and request flag==1 are both true.
REQ-016 SHALL set the request flag on any cycle in which car_sensor==1.
- SHALL clear it on entry to CR_GREEN; set on the same cycle as clear, set wins.
REQ-017 SHALL end CR_GREEN after exactly CR_MAX_GREEN cycles (base behaviour; see REQ-024).
REQ-018 SHALL leave HW_YELLOW, RED1, CR_YELLOW and RED2 when their counter reaches 0, independent of car_sensor.
REQ-019 SHALL drive outputs as registered Moore outputs:
- enable_highway=1 in HW_GREEN and HW_YELLOW only.
- enable_countryroad=1 in CR_GREEN and CR_YELLOW only.
- enable_highway and enable_countryroad SHALL never be 1 together.
REQ-020 SHALL assert timeout for exactly one cycle, in the first cycle of every new phase, and hold it at 0 otherwise.
- A waiting HW_GREEN SHALL produce no timeout pulses.
REQ-021 SHALL make phase equal to the state register; unused encodings 6 and 7 SHALL recover to HW_GREEN on the next cycle with timeout=1.

Reset
REQ-022 SHALL, while rst==1, immediately and asynchronously force:
- state=HW_GREEN, counter=HW_MIN_GREEN-1, request flag=0;
- enable_highway=1, enable_countryroad=0, timeout=0, phase=0.
REQ-023 SHALL, on rst asserted mid-phase (including CR_GREEN), abandon that phase without a yellow or all-red phase.
- After release, HW_GREEN SHALL run its full minimum.

Configuration
REQ-024 SHALL compile in early termination of country-road green when macro CR_EARLY_END_EN is defined:
- CR_GREEN ends once at least CR_MIN_GREEN cycles have elapsed and car_sensor==0, capped at CR_MAX_GREEN.
- Without the macro, CR_GREEN always lasts CR_MAX_GREEN cycles and CR_MIN_GREEN is unused.

Verification
REQ-025 SHALL cover these directed scenarios (default parameters, rst pulsed high 2 cycles at start):
- car_sensor=0 for 100 cycles -> phase stays 0, enable_highway=1, timeout never asserted.
- car_sensor held 1 from cycle 0 -> phase 1 at cycle 16, 2 at 19, 3 at 21, 4 at 33, 5 at 36, 0 at 38; one timeout pulse at each change.
- car_sensor pulsed 1 cycle at cycle 5 -> request latched, HW_GREEN ends at cycle 16, full cycle follows; without a new pulse, stays in HW_GREEN afterwards.
- CR_EARLY_END_EN defined, car_sensor dropped to 0 in CR_GREEN -> CR_GREEN lasts 4 cycles; without macro, 12 cycles.
- rst asserted during CR_GREEN -> same cycle enable_countryroad=0, enable_highway=1, phase=0, timeout=0.
- All runs -> enable_highway & enable_countryroad never both 1.
